// File: rtl/fwd_scoreboard_pkg.sv
// Shared encodings for the forwarding scoreboard and the decode-stage operand mux.
// Holds the result-kind codes, the 3-bit forwarding select codes, the E/M/W
// entry layout and a small address-match helper.
package fwd_scoreboard_pkg;

  // Result source of an in-flight instruction.
  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_LOAD = 2'b01;
  localparam logic [1:0] KIND_LINK = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;  // behaves like ALU

  // Forwarding select codes seen by the operand mux.
  localparam logic [2:0] SEL_RF       = 3'b000;
  localparam logic [2:0] SEL_RESULT_W = 3'b001;
  localparam logic [2:0] SEL_ALU_M    = 3'b010;
  localparam logic [2:0] SEL_NPC_M    = 3'b101;
  localparam logic [2:0] SEL_NPC_W    = 3'b110;

  // One destination-pipeline entry.
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] kind;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '{valid: 1'b0, dst: 5'd0, kind: KIND_ALU};

  // Register 0 is hardwired, so it never matches an in-flight writer.
  function automatic logic entry_hit(input logic valid, input logic [4:0] dst,
                                     input logic [4:0] addr);
    return valid && (dst == addr) && (addr != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port forwarding selector: picks the youngest matching E/M/W writer.
// Ports: addr/rf_rdata of one decode read port, E/M/W entry fields, the four
// forwarding sources; outputs sel code, forwarded data and a stall request.
module fwd_port_sel
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [4:0]    addr,
  input  logic [DW-1:0] rf_rdata,
  input  logic          e_valid,
  input  logic [4:0]    e_dst,
  input  logic          m_valid,
  input  logic [4:0]    m_dst,
  input  logic [1:0]    m_kind,
  input  logic          w_valid,
  input  logic [4:0]    w_dst,
  input  logic [1:0]    w_kind,
  input  logic [DW-1:0] alu_out_M,
  input  logic [DW-1:0] npc_M,
  input  logic [DW-1:0] result_W,
  input  logic [DW-1:0] npc_W,
  output logic [2:0]    sel,
  output logic [DW-1:0] data,
  output logic          stall
);

  logic e_hit;
  logic m_hit;
  logic w_hit;

  assign e_hit = entry_hit(e_valid, e_dst, addr);
  assign m_hit = entry_hit(m_valid, m_dst, addr);
  assign w_hit = entry_hit(w_valid, w_dst, addr);

  // Youngest writer wins. A stalled port reads the register file so the
  // data output is well defined even while the decode stage is held.
  always_comb begin
    sel   = SEL_RF;
    stall = 1'b0;
    if (e_hit) begin
      // Nothing is produced in E yet, so the reader has to wait.
      stall = 1'b1;
    end else if (m_hit) begin
      case (m_kind)
        KIND_LOAD: stall = 1'b1;       // load data only exists in W
        KIND_LINK: sel   = SEL_NPC_M;
        default:   sel   = SEL_ALU_M;  // ALU and reserved
      endcase
    end else if (w_hit) begin
      sel = (w_kind == KIND_LINK) ? SEL_NPC_W : SEL_RESULT_W;
    end
  end

  always_comb begin
    data = rf_rdata;
    case (sel)
      SEL_RESULT_W: data = result_W;
      SEL_ALU_M:    data = alu_out_M;
      SEL_NPC_M:    data = npc_M;
      SEL_NPC_W:    data = npc_W;
      default:      data = rf_rdata;
    endcase
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding scoreboard: tracks E/M/W destinations, drives
// per-port operand select/data and the load-use / E-hazard stall.
// Ports: clk, reset (async high), freeze, flush_E, D-stage issue info,
// read addresses/RF data, forwarding sources; fwd_data_D, fwd_sel_D, stall_D, stall_cnt.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW  = 32,
  parameter int NRP = 2,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              flush_E,
  input  logic              issue_valid_D,
  input  logic [4:0]        issue_dst_D,
  input  logic [1:0]        issue_kind_D,
  input  logic [NRP*5-1:0]  rs_addr_D,
  input  logic [NRP*DW-1:0] rf_rdata_D,
  input  logic [DW-1:0]     alu_out_M,
  input  logic [DW-1:0]     npc_M,
  input  logic [DW-1:0]     result_W,
  input  logic [DW-1:0]     npc_W,
  output logic [NRP*DW-1:0] fwd_data_D,
  output logic [NRP*3-1:0]  fwd_sel_D,
  output logic              stall_D,
  output logic [CW-1:0]     stall_cnt
);

  entry_t         e_q;
  entry_t         m_q;
  entry_t         w_q;
  entry_t         e_next;
  logic [NRP-1:0] port_stall;

  for (genvar i = 0; i < NRP; i++) begin : g_port
    fwd_port_sel #(
      .DW(DW)
    ) u_sel (
      .addr      (rs_addr_D[5*i +: 5]),
      .rf_rdata  (rf_rdata_D[DW*i +: DW]),
      .e_valid   (e_q.valid),
      .e_dst     (e_q.dst),
      .m_valid   (m_q.valid),
      .m_dst     (m_q.dst),
      .m_kind    (m_q.kind),
      .w_valid   (w_q.valid),
      .w_dst     (w_q.dst),
      .w_kind    (w_q.kind),
      .alu_out_M (alu_out_M),
      .npc_M     (npc_M),
      .result_W  (result_W),
      .npc_W     (npc_W),
      .sel       (fwd_sel_D[3*i +: 3]),
      .data      (fwd_data_D[DW*i +: DW]),
      .stall     (port_stall[i])
    );
  end

  // Combinational so the hold takes effect in the same cycle the hazard is seen;
  // an async reset clears the entries and therefore drops the stall at once.
  assign stall_D = |port_stall;

  // A stalled or flushed D instruction leaves a bubble in E; a stalled one
  // re-presents itself next cycle.
  always_comb begin
    e_next = ENTRY_BUBBLE;
    if (issue_valid_D && !stall_D && !flush_E) begin
      e_next.valid = 1'b1;
      e_next.dst   = issue_dst_D;
      e_next.kind  = issue_kind_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= ENTRY_BUBBLE;
      m_q <= ENTRY_BUBBLE;
      w_q <= ENTRY_BUBBLE;
    end else if (!freeze) begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= e_next;
    end
  end

  // Saturating stall counter; frozen cycles are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!freeze && stall_D && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

  localparam int DW  = 32;
  localparam int NRP = 2;
  localparam int CW  = 4;

  localparam logic [31:0] RF0 = 32'h1111_0000;
  localparam logic [31:0] RF1 = 32'h2222_0000;
  localparam logic [31:0] ALU = 32'hA0A0_0001;
  localparam logic [31:0] NPM = 32'hB0B0_0002;
  localparam logic [31:0] RSW = 32'hC0C0_0003;
  localparam logic [31:0] NPW = 32'hD0D0_0004;

  logic              clk = 1'b0;
  logic              reset;
  logic              freeze;
  logic              flush_E;
  logic              issue_valid_D;
  logic [4:0]        issue_dst_D;
  logic [1:0]        issue_kind_D;
  logic [4:0]        rs0, rs1;
  logic [NRP*DW-1:0] rf_rdata_D;
  logic [DW-1:0]     alu_out_M, npc_M, result_W, npc_W;
  logic [NRP*DW-1:0] fwd_data_D;
  logic [NRP*3-1:0]  fwd_sel_D;
  logic              stall_D;
  logic [CW-1:0]     stall_cnt;

  int checks = 0;
  int failures = 0;

  fwd_scoreboard #(.DW(DW), .NRP(NRP), .CW(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .freeze        (freeze),
    .flush_E       (flush_E),
    .issue_valid_D (issue_valid_D),
    .issue_dst_D   (issue_dst_D),
    .issue_kind_D  (issue_kind_D),
    .rs_addr_D     ({rs1, rs0}),
    .rf_rdata_D    (rf_rdata_D),
    .alu_out_M     (alu_out_M),
    .npc_M         (npc_M),
    .result_W      (result_W),
    .npc_W         (npc_W),
    .fwd_data_D    (fwd_data_D),
    .fwd_sel_D     (fwd_sel_D),
    .stall_D       (stall_D),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic issue(input logic v, input logic [1:0] kind, input logic [4:0] dst);
    issue_valid_D = v;
    issue_kind_D  = kind;
    issue_dst_D   = dst;
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; flush_E = 1'b0;
    issue(1'b0, 2'b00, 5'd0);
    rs0 = 5'd5; rs1 = 5'd5;
    rf_rdata_D = {RF1, RF0};
    alu_out_M = ALU; npc_M = NPM; result_W = RSW; npc_W = NPW;

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_stall", stall_D, 0);
    chk("rst_sel", fwd_sel_D, 0);
    chk("rst_data0", fwd_data_D[31:0], RF0);
    chk("rst_data1", fwd_data_D[63:32], RF1);
    chk("rst_cnt", stall_cnt, 0);
    reset = 1'b0; rs0 = 0; rs1 = 0;

    // ALU r5 then read r5
    issue(1'b1, 2'b00, 5'd5); #1;
    chk("alu_issue_nostall", stall_D, 0);
    step;
    issue(1'b0, 2'b00, 5'd0); rs0 = 5'd5; #1;
    chk("alu_e_stall", stall_D, 1);
    chk("alu_e_sel", fwd_sel_D[2:0], 3'b000);
    chk("alu_e_data", fwd_data_D[31:0], RF0);
    step;
    chk("alu_cnt1", stall_cnt, 1);
    chk("alu_m_stall", stall_D, 0);
    chk("alu_m_sel", fwd_sel_D[2:0], 3'b010);
    chk("alu_m_data", fwd_data_D[31:0], ALU);
    step;
    chk("alu_w_sel", fwd_sel_D[2:0], 3'b001);
    chk("alu_w_data", fwd_data_D[31:0], RSW);

    // LOAD r7 then read r7: two stalls
    rs0 = 0; do_reset;
    issue(1'b1, 2'b01, 5'd7); step;
    issue(1'b0, 2'b00, 5'd0); rs0 = 5'd7; #1;
    chk("ld_e_stall", stall_D, 1);
    step;
    chk("ld_m_stall", stall_D, 1);
    chk("ld_m_sel", fwd_sel_D[2:0], 3'b000);
    step;
    chk("ld_w_stall", stall_D, 0);
    chk("ld_w_sel", fwd_sel_D[2:0], 3'b001);
    chk("ld_w_data", fwd_data_D[31:0], RSW);
    chk("ld_cnt2", stall_cnt, 2);

    // LINK r31
    rs0 = 0; do_reset;
    issue(1'b1, 2'b10, 5'd31); step;
    issue(1'b0, 2'b00, 5'd0); step;
    rs0 = 5'd31; #1;
    chk("lnk_m_sel", fwd_sel_D[2:0], 3'b101);
    chk("lnk_m_data", fwd_data_D[31:0], NPM);
    chk("lnk_m_stall", stall_D, 0);
    step;
    rs1 = 5'd31; #1;
    chk("lnk_w_sel0", fwd_sel_D[2:0], 3'b110);
    chk("lnk_w_data0", fwd_data_D[31:0], NPW);
    chk("lnk_w_sel1", fwd_sel_D[5:3], 3'b110);
    chk("lnk_w_data1", fwd_data_D[63:32], NPW);

    // write r0, read r0 on both ports
    rs0 = 0; rs1 = 0; do_reset;
    issue(1'b1, 2'b00, 5'd0); step;
    issue(1'b0, 2'b00, 5'd0); #1;
    chk("r0_stall", stall_D, 0);
    chk("r0_sel", fwd_sel_D, 0);
    chk("r0_data0", fwd_data_D[31:0], RF0);
    chk("r0_data1", fwd_data_D[63:32], RF1);

    // M and W both hold ALU r3: youngest wins
    do_reset;
    issue(1'b1, 2'b00, 5'd3); step; step;
    issue(1'b0, 2'b00, 5'd0); step;
    rs1 = 5'd3; #1;
    chk("yng_sel1", fwd_sel_D[5:3], 3'b010);
    chk("yng_data1", fwd_data_D[63:32], ALU);
    chk("yng_sel0", fwd_sel_D[2:0], 3'b000);
    chk("yng_stall", stall_D, 0);

    // flush_E kills the issue
    rs1 = 0; do_reset;
    issue(1'b1, 2'b00, 5'd9); flush_E = 1'b1; step;
    flush_E = 1'b0; issue(1'b0, 2'b00, 5'd0); rs0 = 5'd9; #1;
    chk("flush_stall", stall_D, 0);
    chk("flush_sel", fwd_sel_D[2:0], 3'b000);

    // reserved kind behaves as ALU
    rs0 = 0; do_reset;
    issue(1'b1, 2'b11, 5'd4); step;
    issue(1'b0, 2'b00, 5'd0); step;
    rs0 = 5'd4; #1;
    chk("rsvd_sel", fwd_sel_D[2:0], 3'b010);
    chk("rsvd_data", fwd_data_D[31:0], ALU);

    // an issue during a stall is not captured
    rs0 = 0; do_reset;
    issue(1'b1, 2'b00, 5'd5); step;
    issue(1'b1, 2'b00, 5'd6); rs0 = 5'd5; #1;
    chk("hold_stall", stall_D, 1);
    step;
    issue(1'b0, 2'b00, 5'd0); rs0 = 5'd6; #1;
    chk("hold_nocap_stall", stall_D, 0);
    chk("hold_nocap_sel", fwd_sel_D[2:0], 3'b000);

    // freeze holds a pending stall, reset clears it asynchronously
    rs0 = 0; do_reset;
    issue(1'b1, 2'b01, 5'd6); step;
    issue(1'b0, 2'b00, 5'd0); rs0 = 5'd6; step;
    chk("frz_pre_cnt", stall_cnt, 1);
    freeze = 1'b1; flush_E = 1'b1;
    for (int i = 0; i < 3; i++) step;
    #1;
    chk("frz_stall", stall_D, 1);
    chk("frz_cnt", stall_cnt, 1);
    reset = 1'b1; #1;
    chk("frz_rst_stall", stall_D, 0);
    chk("frz_rst_cnt", stall_cnt, 0);
    chk("frz_rst_sel", fwd_sel_D[2:0], 3'b000);
    chk("frz_rst_data", fwd_data_D[31:0], RF0);
    reset = 1'b0; freeze = 1'b0; flush_E = 1'b0; rs0 = 0; #1;

    // counter saturation (CW=4 -> 15)
    for (int i = 0; i < 14; i++) begin
      issue(1'b1, 2'b00, 5'd8); rs0 = 5'd0; step;
      issue(1'b0, 2'b00, 5'd0); rs0 = 5'd8; step;
    end
    chk("sat_cnt14", stall_cnt, 14);
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 2'b00, 5'd8); rs0 = 5'd0; step;
      issue(1'b0, 2'b00, 5'd0); rs0 = 5'd8; step;
    end
    chk("sat_cnt15", stall_cnt, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DW, default 32: datapath width in bits.
REQ-002 Parameter NRP, default 2: number of decode-stage read ports to be forwarded.
REQ-003 Parameter CW, default 16: width of the stall-cycle counter.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 freeze  in  1  global pipeline hold, e.g. a memory wait; the scoreboard holds all state.
REQ-007 flush_E  in  1  kill the instruction entering E this cycle.
REQ-008 issue_valid_D  in  1  the D-stage instruction writes a register.
REQ-009 issue_dst_D  in  5  destination register of the D-stage instruction.
REQ-010 issue_kind_D  in  2  result source: 00 ALU, 01 LOAD, 10 LINK (npc), 11 reserved, treated as ALU.
REQ-011 rs_addr_D  in  NRP*5  read-port register addresses; port i occupies bits [5i+4:5i].
REQ-012 rf_rdata_D  in  NRP*DW  register-file read data per port.
REQ-013 alu_out_M, npc_M, result_W, npc_W  in  DW each  forwarding sources.
REQ-014 fwd_data_D  out  NRP*DW  forwarded operand per port.
REQ-015 fwd_sel_D  out  NRP*3  per-port select code: 000 RF, 001 result_W, 010 alu_out_M, 101 npc_M, 110 npc_W.
REQ-016 stall_D  out  1  hold F/D and insert a bubble into E.
REQ-017 stall_cnt  out  CW  saturating count of cycles with stall_D=1 and freeze=0.

Function
REQ-018 Internal state: three entries E, M and W, each holding {valid, dst[4:0], kind[1:0]}, which mirror the destination pipeline.
REQ-019 Cycle advance when freeze=0: W<=M and M<=E; E<=D-issue if stall_D=0 and flush_E=0, otherwise E<=bubble (valid=0).
REQ-020 When freeze=1, E, M, W and stall_cnt hold their values; flush_E is ignored.
REQ-021 An entry matches port i iff valid=1, dst==rs_addr[i] and rs_addr[i]!=0; register 0 never forwards or stalls.
REQ-022 Priority per port is E > M > W > RF; only the youngest matching entry is considered.
REQ-023 An E match forces a stall for that port, since no E-stage source exists.
REQ-024 An M match with kind ALU selects code 010, with kind LINK selects code 101, and with kind LOAD forces a stall.
REQ-025 A W match with kind ALU or LOAD selects code 001; with kind LINK it selects code 110.
REQ-026 stall_D is the OR over all ports of the per-port stall conditions; it is combinational, with no cycle of latency.
REQ-027 When a port stalls, its fwd_sel is 000 and its fwd_data equals rf_rdata.
REQ-028 fwd_data_D and fwd_sel_D are purely combinational from state and inputs, with zero latency.
REQ-029 stall_cnt increments by 1 per counted cycle and saturates at 2^CW-1 without wrapping.
REQ-030 When stall_D=1, issue_valid_D is not captured into E; the same instruction re-issues in the next cycle.

Reset
REQ-031 While reset=1, all entry valid bits are 0, dst=0, kind=0 and stall_cnt=0, asynchronously.
REQ-032 Consequently, during and just after reset: stall_D=0, all fwd_sel=000, and fwd_data equals rf_rdata.
REQ-033 A reset asserted mid-stall clears the stall immediately, without waiting for a clock edge.

Structure
REQ-034 A shared package holds the kind encodings (ALU, LOAD, LINK) and the five 3-bit select codes; the decode-stage operand mux uses the same package.
REQ-035 One sub-module, fwd_port_sel, is instantiated NRP times; given one address plus the E/M/W entries, it produces sel, data and a per-port stall.
REQ-036 The E/M/W entry registers and stall_cnt live in the top level only.

Verification
REQ-037 Issue ALU r5 -> next cycle read r5 on port 0 -> stall_D=1, stall_cnt=1; following cycle sel0=010, data0=alu_out_M.
REQ-038 Issue LOAD r7, then read r7 -> two stall cycles (E, then M) -> third cycle sel=001, data=result_W, stall_cnt=2.
REQ-039 Issue LINK r31, idle one cycle, read r31 -> sel=101 (npc_M); hold the read one more cycle without a new issue -> sel=110 (npc_W).
REQ-040 Write r0 as ALU, then read r0 on both ports -> stall_D=0, sel=000, data=rf_rdata.
REQ-041 M holds ALU r3 and W holds ALU r3; read r3 on port 1 -> sel1=010, because the youngest entry wins.
REQ-042 Stall pending with freeze=1 for 3 cycles -> state and stall_cnt unchanged; assert reset mid-freeze -> stall_D=0 and stall_cnt=0 before the next edge.
